// File: rtl/button_conditioner.sv
// button_conditioner: input conditioning for the breakout game buttons.
// Each channel is synchronised (two flops), debounced with a per-channel
// counter, and turned into a clean level plus single-cycle press/release
// strobes.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   When defined, channels selected by REPEAT_MASK emit extra btn_press
//   strobes while held: the first REPEAT_DELAY cycles after the accepted
//   press, then every REPEAT_PERIOD cycles.
//
// Ports:
//   clk          system clock (pixel clock domain)
//   rst          synchronous reset, active-high
//   btn_raw      asynchronous raw button pins, 1 = pressed
//   btn_level    debounced level, 1 = pressed
//   btn_press    1-cycle strobe on accepted press (and on auto-repeat)
//   btn_release  1-cycle strobe on accepted release
module button_conditioner #(
  parameter int unsigned        NUM_BTN         = 3,
  parameter int unsigned        DEBOUNCE_CYCLES = 65536,
  parameter int unsigned        REPEAT_DELAY    = 6250000,
  parameter int unsigned        REPEAT_PERIOD   = 1562500,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(3'b011)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] stable_q, stable_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned       REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                            : REPEAT_PERIOD;
  localparam int unsigned       RCNT_W     = $clog2(REP_MAX + 1);
  localparam logic [RCNT_W-1:0] RPT_DELAY  = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RPT_PERIOD = RCNT_W'(REPEAT_PERIOD);

  logic [RCNT_W-1:0]  rcnt_q [NUM_BTN];
  logic [RCNT_W-1:0]  rcnt_d [NUM_BTN];
  // Set once the first repeat has fired; selects PERIOD instead of DELAY.
  logic [NUM_BTN-1:0] rep_q, rep_d;
`else
  // Repeat configuration has no effect in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, REPEAT_MASK};
`endif

  // Debounce and strobe generation.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i]  = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    // Repeat counter runs only while held; the release cycle clears it
    // and suppresses any repeat so press and release never coincide.
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      rcnt_d[i] = '0;
      rep_d[i]  = 1'b0;
      if (REPEAT_MASK[i] && stable_q[i] && !release_d[i]) begin
        rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
        rep_d[i]  = rep_q[i];
        if (rcnt_d[i] == (rep_q[i] ? RPT_PERIOD : RPT_DELAY)) begin
          press_d[i] = 1'b1;
          rcnt_d[i]  = '0;
          rep_d[i]   = 1'b1;
        end
      end
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '{default: '0};
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= '{default: '0};
      rep_q     <= '0;
`endif
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_q    <= rcnt_d;
      rep_q     <= rep_d;
`endif
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Reference model: a change is accepted when the last
// DEBOUNCE_CYCLES post-reset synchronised samples all differ from the level.
module tb_button_conditioner;

  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 10;
  localparam int unsigned RP   = 3;
  localparam logic [2:0]  MASK = 3'b011;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;

  logic [2:0] m_level, m_press, m_release;
  logic [2:0] hist[$];
  int         edge_n;
  int         acc_edge[3];
  int         n_checks;
  int         n_fail;

  button_conditioner #(
    .NUM_BTN(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the reference model by one rising edge with the given inputs.
  task automatic model_step(input logic [2:0] raw, input logic r);
    logic flip;
    m_press   = '0;
    m_release = '0;
    if (r) begin
      m_level = '0;
      hist.delete();
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        flip = (hist.size() == int'(D) + 1);
        for (int j = 0; j < int'(D); j++)
          if (flip && hist[j][ch] == m_level[ch]) flip = 1'b0;
        if (flip) begin
          if (m_level[ch]) m_release[ch] = 1'b1;
          else begin
            m_press[ch]  = 1'b1;
            acc_edge[ch] = edge_n;
          end
          m_level[ch] = ~m_level[ch];
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (m_level[ch] && MASK[ch]) begin
          int k;
          k = edge_n - acc_edge[ch];
          if (k == int'(RD) || (k > int'(RD) && (k - int'(RD)) % int'(RP) == 0))
            m_press[ch] = 1'b1;
        end
`endif
      end
      hist.push_back(raw);
      if (hist.size() > int'(D) + 1) void'(hist.pop_front());
    end
    edge_n++;
  endtask

  // Drive inputs away from the edge, step the model, land on the next negedge.
  task automatic drive_cycle(input logic [2:0] raw, input logic r);
    btn_raw = raw;
    rst     = r;
    model_step(raw, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int e = 0; e < 23; e++) begin
      drive_cycle(3'b000, e < 3);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset e=%0d got lvl=%b pr=%b rl=%b expected all 0",
                 e, btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_single_press();
    logic el, ep;
    for (int e = 0; e < 16; e++) begin
      drive_cycle((e < 8) ? 3'b001 : 3'b000, 1'b0);
      el = (e >= 5 && e < 13);
      ep = (e == 5);
      n_checks++;
      if (btn_level[0] !== el || btn_press[0] !== ep || btn_release[0] !== (e == 13)) begin
        n_fail++;
        $display("FAIL single_press e=%0d got lvl=%b pr=%b rl=%b expected lvl=%b pr=%b rl=%b",
                 e, btn_level[0], btn_press[0], btn_release[0], el, ep, e == 13);
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL single_press_model e=%0d got %b expected %b", e,
                 {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
      end
    end
  endtask

  task automatic test_bounce();
    logic b;
    for (int e = 0; e < 22; e++) begin
      b = (e < 5) ? (e % 2 == 0) : (e < 14);
      drive_cycle({1'b0, b, 1'b0}, 1'b0);
      n_checks++;
      if (btn_press[1] !== (e == 9) || btn_level[1] !== (e >= 9 && e < 19)) begin
        n_fail++;
        $display("FAIL bounce e=%0d got lvl=%b pr=%b expected lvl=%b pr=%b",
                 e, btn_level[1], btn_press[1], e >= 9 && e < 19, e == 9);
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL bounce_model e=%0d got %b expected %b", e,
                 {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
      end
    end
  endtask

  task automatic test_release();
    for (int e = 0; e < 8; e++) drive_cycle(3'b100, 1'b0);
    for (int e = 0; e < 8; e++) begin
      drive_cycle(3'b000, 1'b0);
      n_checks++;
      if (btn_release[2] !== (e == 5) || btn_press[2] !== 1'b0 || btn_level[2] !== (e < 5)) begin
        n_fail++;
        $display("FAIL release e=%0d got lvl=%b pr=%b rl=%b expected lvl=%b pr=0 rl=%b",
                 e, btn_level[2], btn_press[2], btn_release[2], e < 5, e == 5);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int e = 0; e < 16; e++) begin
      drive_cycle((e < 8) ? 3'b111 : 3'b000, 1'b0);
      n_checks++;
      if (btn_press !== ((e == 5) ? 3'b111 : 3'b000) ||
          btn_release !== ((e == 13) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL simultaneous e=%0d got pr=%b rl=%b", e, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ep, el;
    for (int e = 0; e < 28; e++) begin
      drive_cycle((e < 20) ? 3'b111 : 3'b000, e == 2 || e == 11);
      ep = (e == 8 || e == 17) ? 3'b111 : 3'b000;
      el = ((e >= 8 && e <= 10) || (e >= 17 && e < 25)) ? 3'b111 : 3'b000;
      n_checks++;
      if (btn_press !== ep || btn_level !== el) begin
        n_fail++;
        $display("FAIL reset_mid e=%0d got lvl=%b pr=%b expected lvl=%b pr=%b",
                 e, btn_level, btn_press, el, ep);
      end
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL reset_mid_model e=%0d got %b expected %b", e,
                 {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
      end
    end
  endtask

  task automatic test_autorepeat();
    logic e0;
    int   n2;
    n2 = 0;
    for (int e = 0; e < 31; e++) begin
      drive_cycle(3'b101, 1'b0);
      if (btn_press[2]) n2++;
`ifdef BTN_AUTOREPEAT_EN
      e0 = (e == 5 || e == 15 || e == 18 || e == 21 || e == 24 || e == 27 || e == 30);
`else
      e0 = (e == 5);
`endif
      n_checks++;
      if (btn_press[0] !== e0) begin
        n_fail++;
        $display("FAIL autorepeat_ch0 e=%0d got pr=%b expected %b", e, btn_press[0], e0);
      end
    end
    n_checks++;
    if (n2 != 1) begin
      n_fail++;
      $display("FAIL autorepeat_ch2 got %0d strobes expected 1", n2);
    end
    // Release edge lands exactly on a repeat slot; that repeat must not fire.
    for (int r = 0; r < 8; r++) begin
      drive_cycle(3'b000, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
      e0 = (r == 2);
`else
      e0 = 1'b0;
`endif
      n_checks++;
      if (btn_press[0] !== e0 || btn_release[0] !== (r == 5)) begin
        n_fail++;
        $display("FAIL autorepeat_release r=%0d got pr=%b rl=%b expected pr=%b rl=%b",
                 r, btn_press[0], btn_release[0], e0, r == 5);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] rv;
    logic       r;
    int         hold[3];
    rv   = '0;
    hold = '{0, 0, 0};
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (hold[ch] == 0) begin
          rv[ch]   = 1'($urandom_range(0, 1));
          hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 6);
        end
        hold[ch]--;
      end
      r = ($urandom_range(0, 249) == 0);
      drive_cycle(rv, r);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
        n_fail++;
        $display("FAIL random c=%0d raw=%b rst=%b got lvl=%b pr=%b rl=%b expected lvl=%b pr=%b rl=%b",
                 c, rv, r, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    edge_n    = 0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    acc_edge  = '{0, 0, 0};
    rst       = 1'b1;
    btn_raw   = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
